ffsr_spike_tx: RTL
==================

# ffsr_spike_tx

Spike-train transmitter for FFSR counters, the sending end of the spike-encoded inc/dec interface. It accepts a signed delta and emits |delta| spikes on the increment line (positive delta) or the decrement line (negative delta). A spike is a high-to-low transition on a line that idles high. The outputs connect directly to the `inc`/`dec` inputs of a spike-encoded FFSR in the same clock domain, so that counter moves by exactly `delta`.

## Interface
- `INPUT_SIZE`, 8: width of `delta` and `remaining`.
- `LOW_CYCLES`, 1: cycles a spike line is held low per spike; must be ≥1.
- `HIGH_CYCLES`, 1: minimum cycles a line is held high after each spike; must be ≥1 so the receiver re-arms.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; accepted on a rising edge where `start && ready`.
- `delta`  in  INPUT_SIZE  signed two's-complement spike count; sampled on accept.
- `abort`  in  1  synchronous cancel of the current train.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse when a train completes normally.
- `inc_spk`  out  1  increment spike line, idles high.
- `dec_spk`  out  1  decrement spike line, idles high.
- `remaining`  out  INPUT_SIZE  unsigned count of spikes not yet completed.

## Operation
- States: IDLE, LOW, HIGH, DONE. All outputs are registered.
- Reset (async) forces IDLE, `inc_spk`=`dec_spk`=1, `ready`=1, `done`=0, `remaining`=0, and clears the direction flag and phase counter. A spike is never produced by reset.
- IDLE:
  - On accept, latch `dir` = `delta[MSB]` and `mag` = |delta|, computed modulo 2^INPUT_SIZE as unsigned. The most-negative value (-128 at 8 bits) yields `mag`=128.
  - Load `remaining`=`mag`.
  - If `mag`≠0, go to LOW; if `mag`=0, go to DONE.
- LOW:
  - The selected line (`inc_spk` if `dir`=0, else `dec_spk`) is driven low. The other line stays high.
  - Lasts LOW_CYCLES cycles. On leaving, `remaining` decrements by 1 and the state goes to HIGH.
- HIGH:
  - Both lines are high for HIGH_CYCLES cycles.
  - Then go to LOW if `remaining`≠0, else to DONE.
- DONE: `done`=1 for exactly one cycle, `ready`=0, then IDLE.
- `start` while `ready`=0 is ignored; no queuing.
- `abort` in LOW, HIGH or DONE:
  - Next state is IDLE, both lines high, `remaining`=0, no `done` pulse.
  - An aborted LOW phase still counts as a delivered spike at the receiver, because its falling edge was already sent.
  - `abort` in IDLE has no effect. `abort` with `start` in IDLE: `abort` wins, no accept.
- Reset mid-train returns the lines high asynchronously; no `done`.
- `inc_spk` and `dec_spk` are never low simultaneously.

## Timing
- Accept at edge 0.
- First line low in cycle 1 (the cycle after the accepting edge). Latency from accept to first spike is 1 cycle.
- Spike j (0-based) is low during cycles 1+j·P … j·P+LOW_CYCLES, where P = LOW_CYCLES+HIGH_CYCLES.
- For a train of N≥1 spikes:
  - `done` is high in cycle 1+N·P.
  - `ready` returns high in cycle 2+N·P.
- For N=0: `done` is high in cycle 1 and `ready` in cycle 2.
- `remaining` shows N−j−1 from the first cycle of spike j's HIGH phase.
- Phase counter width is clog2(max(LOW_CYCLES, HIGH_CYCLES))+1. `remaining` never wraps.

## Test plan
- Reset, including assertion mid-LOW with `delta`=+4: lines go high in the same cycle, `ready`=1, `remaining`=0, `done`=0, and the receiver counter is unchanged by the reset.
- `delta`=+3, L=H=1, accept at edge 0: `inc_spk` low in cycles 1, 3, 5 only; `dec_spk` stays high; `remaining` steps 3→2→1→0; `done` high in cycle 7; `ready` high in cycle 8.
- `delta`=0xFE (−2), L=2, H=3: `dec_spk` low in cycles 1–2 and 6–7; `done` in cycle 11. `delta`=0x00 gives `done` in cycle 1 with no spikes. `delta`=0x80 gives 128 `dec_spk` spikes.
- Timing-independent checks: `start` asserted during a train is ignored and `ready` stays 0. `abort` in cycle 4 of a `delta`=+5 train (L=H=1) gives two spikes delivered, lines high from cycle 5, and no `done`.
- End-to-end with a spike-encoded FFSR (init 10, both in reset together):
  - Send +5, then −7: counter reads 15, then 8.
  - Send −128 from init 200: counter reads 72.

Source files
------------

// File: rtl/ffsr_spike_tx.sv
// Spike-train transmitter for spike-encoded FFSR counters.
// Turns a signed delta into |delta| high-to-low spikes on inc_spk (delta>0)
// or dec_spk (delta<0). Both lines idle high; every output is registered.
module ffsr_spike_tx #(
  parameter int INPUT_SIZE  = 8,
  parameter int LOW_CYCLES  = 1,
  parameter int HIGH_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INPUT_SIZE-1:0] delta,
  input  logic                  abort,
  output logic                  ready,
  output logic                  done,
  output logic                  inc_spk,
  output logic                  dec_spk,
  output logic [INPUT_SIZE-1:0] remaining
);

  localparam int MAX_CYC = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
  localparam int PW      = $clog2(MAX_CYC) + 1;

  localparam logic [PW-1:0]         LOW_LAST  = PW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0]         HIGH_LAST = PW'(HIGH_CYCLES - 1);
  localparam logic [PW-1:0]         PH_ONE    = PW'(1);
  localparam logic [INPUT_SIZE-1:0] ONE       = INPUT_SIZE'(1);
  localparam logic [INPUT_SIZE-1:0] ZERO      = '0;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_DONE} state_t;

  state_t                  state;
  logic                    dir;    // 0: increment line, 1: decrement line
  logic [PW-1:0]           phase;
  logic [INPUT_SIZE-1:0]   mag;
  logic                    neg;

  // Magnitude modulo 2^INPUT_SIZE, so the most-negative value maps to 2^(N-1).
  assign neg = delta[INPUT_SIZE-1];
  assign mag = neg ? ((~delta) + ONE) : delta;

  // Train sequencer: IDLE -> (LOW -> HIGH)* -> DONE -> IDLE, abort returns to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      inc_spk   <= 1'b1;
      dec_spk   <= 1'b1;
      ready     <= 1'b1;
      done      <= 1'b0;
      remaining <= ZERO;
      dir       <= 1'b0;
      phase     <= '0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && abort) begin
        // A LOW cut short still delivered its falling edge; just go quiet.
        state     <= S_IDLE;
        inc_spk   <= 1'b1;
        dec_spk   <= 1'b1;
        ready     <= 1'b1;
        remaining <= ZERO;
        phase     <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start && ready && !abort) begin
              dir       <= neg;
              remaining <= mag;
              phase     <= '0;
              ready     <= 1'b0;
              if (mag != ZERO) begin
                state   <= S_LOW;
                inc_spk <= neg;
                dec_spk <= !neg;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end
          end
          S_LOW: begin
            if (phase == LOW_LAST) begin
              phase   <= '0;
              inc_spk <= 1'b1;
              dec_spk <= 1'b1;
              state   <= S_HIGH;
              if (remaining != ZERO) remaining <= remaining - ONE;
            end else begin
              phase <= phase + PH_ONE;
            end
          end
          S_HIGH: begin
            if (phase == HIGH_LAST) begin
              phase <= '0;
              if (remaining != ZERO) begin
                state   <= S_LOW;
                inc_spk <= dir;
                dec_spk <= !dir;
              end else begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              phase <= phase + PH_ONE;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            ready <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
